id_ex_hazard_reg: RTL

- ID/EX pipeline register plus the load-use interlock and branch-flush control for the 5-stage MIPS pipeline.
- Consumes the IF/ID outputs (PC4, Inst) and ID-stage decode results, and latches them for EX.
- Drives the stall and flush signals back to the PC and to the IF/ID register.
- Inserts bubbles and keeps hazard statistics counters.

---
 rtl/id_ex_hazard_reg.sv | 137 +++++++++++++
 1 files changed

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: the ID/EX pipeline register for the 5-stage MIPS pipeline,
// together with the load-use interlock and the taken-branch flush control.
//
// Ports:
//   Clk, Reset             negedge-updated clock; asynchronous active-high reset
//   I_PC4/I_RD1/I_RD2/I_Imm  ID-stage datapath values (DW bits)
//   I_Inst                 IF/ID instruction (rs/rt/rd fields extracted here)
//   I_Ctrl                 {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[2:0]}
//   I_UsesRt               ID instruction reads rt as a source
//   Br_Taken               EX-stage branch/jump resolved taken this cycle
//   PC4/RD1/RD2/Imm/Rs/Rt/Rd/Ctrl  registered EX-stage values
//   Stall, IFID_Flush      combinational hazard controls to PC and IF/ID
//   Stall_Cnt, Flush_Cnt   saturating hazard statistics counters
module id_ex_hazard_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [DW-1:0] I_PC4,
  input  logic [31:0]   I_Inst,
  input  logic [DW-1:0] I_RD1,
  input  logic [DW-1:0] I_RD2,
  input  logic [DW-1:0] I_Imm,
  input  logic [8:0]    I_Ctrl,
  input  logic          I_UsesRt,
  input  logic          Br_Taken,
  output logic [DW-1:0] PC4,
  output logic [DW-1:0] RD1,
  output logic [DW-1:0] RD2,
  output logic [DW-1:0] Imm,
  output logic [4:0]    Rs,
  output logic [4:0]    Rt,
  output logic [4:0]    Rd,
  output logic [8:0]    Ctrl,
  output logic          Stall,
  output logic          IFID_Flush,
  output logic [CW-1:0] Stall_Cnt,
  output logic [CW-1:0] Flush_Cnt
);

  localparam int unsigned RW       = 5;
  localparam int unsigned CTW      = 9;
  localparam int unsigned MEMRD_IX = 7;

  logic [DW-1:0]  pc4_q, pc4_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [RW-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CTW-1:0] ctrl_q, ctrl_d;
  logic [CW-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          ex_mem_read, rs_match, rt_match, hazard;
  logic          unused_inst_bits;

  assign id_rs = I_Inst[25:21];
  assign id_rt = I_Inst[20:16];
  assign id_rd = I_Inst[15:11];
  assign unused_inst_bits = ^{I_Inst[31:26], I_Inst[10:0]};

  // Load-use detect against the load currently in EX. MemRead gates every
  // term so an unknown instruction cannot leak into Stall while EX is idle.
  assign ex_mem_read = ctrl_q[MEMRD_IX];
  assign rs_match    = (rt_q == id_rs);
  assign rt_match    = I_UsesRt & (rt_q == id_rt);
  assign hazard      = ex_mem_read & (rt_q != RW'(0)) & (rs_match | rt_match);

  // A taken branch squashes the ID instruction, so stalling for it is moot.
  assign Stall      = hazard & ~Br_Taken;
  assign IFID_Flush = Br_Taken;

  // Next-state: bubble by default, flush beats stall, otherwise latch ID.
  always_comb begin
    pc4_d       = DW'(0);
    rd1_d       = DW'(0);
    rd2_d       = DW'(0);
    imm_d       = DW'(0);
    rs_d        = RW'(0);
    rt_d        = RW'(0);
    rd_d        = RW'(0);
    ctrl_d      = CTW'(0);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (Br_Taken) begin
      if (flush_cnt_q != {CW{1'b1}}) flush_cnt_d = flush_cnt_q + CW'(1);
    end else if (hazard) begin
      if (stall_cnt_q != {CW{1'b1}}) stall_cnt_d = stall_cnt_q + CW'(1);
    end else begin
      pc4_d  = I_PC4;
      rd1_d  = I_RD1;
      rd2_d  = I_RD2;
      imm_d  = I_Imm;
      rs_d   = id_rs;
      rt_d   = id_rt;
      rd_d   = id_rd;
      ctrl_d = I_Ctrl;
    end
  end

  // State register, updated on the falling edge like the other pipe registers.
  always_ff @(negedge Clk or posedge Reset) begin
    if (Reset) begin
      pc4_q       <= DW'(0);
      rd1_q       <= DW'(0);
      rd2_q       <= DW'(0);
      imm_q       <= DW'(0);
      rs_q        <= RW'(0);
      rt_q        <= RW'(0);
      rd_q        <= RW'(0);
      ctrl_q      <= CTW'(0);
      stall_cnt_q <= CW'(0);
      flush_cnt_q <= CW'(0);
    end else begin
      pc4_q       <= pc4_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC4       = pc4_q;
  assign RD1       = rd1_q;
  assign RD2       = rd2_q;
  assign Imm       = imm_q;
  assign Rs        = rs_q;
  assign Rt        = rt_q;
  assign Rd        = rd_q;
  assign Ctrl      = ctrl_q;
  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;

endmodule
